memory_stage: RTL and testbench

- Memory stage of the pipelined MIPS core.
- Consumes one execute_data_t per handshake from the execute stage.
- For loads and stores:
  - checks alignment;
  - issues a single data-bus request;
  - waits for the split address/data response;
  - aligns and extends the load data.
- Emits one memory_data_t per instruction toward writeback, and stalls upstream while a bus transaction is outstanding.

---
 rtl/common_pkg.sv | 51 +++++
 rtl/memory_pkg.sv | 52 +++++
 rtl/memory_align.sv | 41 ++++
 rtl/memory_stage.sv | 148 ++++++++++++++
 tb/tb_memory_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Types shared across the pipeline: decoded instructions, execute payload and
// the split address/data bus used by the memory stage.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADDU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW
    } decoded_op_t;

    typedef struct packed {
        decoded_op_t op;
    } decoded_instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        decoded_instr_t instr;
        logic [4:0]     writereg;
        logic [31:0]    aluout;
        logic [31:0]    writedata;
        logic [31:0]    hi;
        logic [31:0]    lo;
        logic [31:0]    pcplus4;
        logic           in_delay_slot;
        logic [31:0]    cp0_cause;
        logic [31:0]    cp0_status;
        logic           exception_instr;
        logic           exception_ri;
        logic           exception_of;
        logic           i_tlb_refill;
        logic           i_tlb_invalid;
    } execute_data_t;

endpackage

// File: rtl/memory_pkg.sv
// Memory-stage types: FSM state, decoded access descriptor and the payload
// handed to writeback.
package memory_pkg;
    import common::*;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} mem_state_t;

    typedef struct packed {
        logic   read;
        logic   write;
        msize_t size;
        logic   sign;
    } mem_op_t;

    typedef struct packed {
        decoded_instr_t instr;
        logic [4:0]     writereg;
        logic [31:0]    hi;
        logic [31:0]    lo;
        logic [31:0]    pcplus4;
        logic           in_delay_slot;
        logic [31:0]    cp0_cause;
        logic [31:0]    cp0_status;
        logic           exception_instr;
        logic           exception_ri;
        logic           exception_of;
        logic           i_tlb_refill;
        logic           i_tlb_invalid;
        logic [31:0]    result;
        logic           exception_adel;
        logic           exception_ades;
        logic [31:0]    badvaddr;
    } memory_data_t;

    function automatic mem_op_t decode_mem_op(input decoded_instr_t di);
        mem_op_t m;
        m = '{read: 1'b0, write: 1'b0, size: MSIZE4, sign: 1'b0};
        case (di.op)
            OP_LB:   m = '{read: 1'b1, write: 1'b0, size: MSIZE1, sign: 1'b1};
            OP_LBU:  m = '{read: 1'b1, write: 1'b0, size: MSIZE1, sign: 1'b0};
            OP_LH:   m = '{read: 1'b1, write: 1'b0, size: MSIZE2, sign: 1'b1};
            OP_LHU:  m = '{read: 1'b1, write: 1'b0, size: MSIZE2, sign: 1'b0};
            OP_LW:   m = '{read: 1'b1, write: 1'b0, size: MSIZE4, sign: 1'b0};
            OP_SB:   m = '{read: 1'b0, write: 1'b1, size: MSIZE1, sign: 1'b0};
            OP_SH:   m = '{read: 1'b0, write: 1'b1, size: MSIZE2, sign: 1'b0};
            OP_SW:   m = '{read: 1'b0, write: 1'b1, size: MSIZE4, sign: 1'b0};
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memory_align.sv
// Byte-lane steering: store strobe/data replication, load shift/extend and
// the alignment check. Purely combinational.
module memory_align
    import common::*;
    import memory_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  strobe,
    output logic [31:0] sdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;

    always_comb begin
        misaligned = (op.read || op.write) &&
                     ((op.size == MSIZE2 && addr_lo[0]) ||
                      (op.size == MSIZE4 && addr_lo != 2'b00));

        case (op.size)
            MSIZE1:  begin strobe = 4'b0001 << addr_lo; sdata = {4{wdata[7:0]}};  end
            MSIZE2:  begin strobe = 4'b0011 << addr_lo; sdata = {2{wdata[15:0]}}; end
            default: begin strobe = 4'hF;               sdata = wdata;            end
        endcase
        if (!op.write)
            strobe = 4'h0;

        // The addressed byte/halfword is brought down to bit 0 before extension.
        shifted = rdata >> {addr_lo, 3'b000};
        case (op.size)
            MSIZE1:  ldata = {{24{op.sign & shifted[7]}},  shifted[7:0]};
            MSIZE2:  ldata = {{16{op.sign & shifted[15]}}, shifted[15:0]};
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: one execute result per handshake, at most one outstanding
// data-bus transaction, registered result toward writeback.
module memory_stage
    import common::*;
    import memory_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  execute_data_t in_data,
    output logic          in_ready,
    input  logic          flush,
    output logic          dreq_valid,
    output logic [31:0]   dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [3:0]    dreq_strobe,
    output logic [31:0]   dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  logic [31:0]   dresp_data,
    output logic          out_valid,
    output memory_data_t  out_data,
    input  logic          out_ready,
    output logic          stall
);

    mem_state_t   state, state_next;
    mem_op_t      in_op, op_q, align_op;
    memory_data_t out_q, in_md;
    dbus_req_t    dreq;
    logic [31:0]  addr_q, data_q, sdata, ldata;
    logic [3:0]   strobe_q, strobe;
    logic [1:0]   align_addr;
    logic         flushed_q, accept, in_bypass, misaligned, complete, squash;

    assign in_op    = decode_mem_op(in_data.instr);
    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign stall    = (state == ADDR) || (state == DATA);
    assign squash   = flushed_q || flush;
    assign complete = (state == ADDR && dresp_addr_ok && dresp_data_ok) ||
                      (state == DATA && dresp_data_ok);

    assign in_bypass = !(in_op.read || in_op.write) || in_data.exception_instr ||
                       in_data.exception_ri || in_data.exception_of ||
                       in_data.i_tlb_refill || in_data.i_tlb_invalid;

    // While a transaction is open the aligner works on the held request,
    // otherwise on the incoming instruction.
    assign align_op   = stall ? op_q : in_op;
    assign align_addr = stall ? addr_q[1:0] : in_data.aluout[1:0];

    memory_align u_align (
        .op         (align_op),
        .addr_lo    (align_addr),
        .wdata      (in_data.writedata),
        .rdata      (dresp_data),
        .misaligned (misaligned),
        .strobe     (strobe),
        .sdata      (sdata),
        .ldata      (ldata)
    );

    always_comb begin
        in_md                 = '0;
        in_md.instr           = in_data.instr;
        in_md.writereg        = in_data.writereg;
        in_md.hi              = in_data.hi;
        in_md.lo              = in_data.lo;
        in_md.pcplus4         = in_data.pcplus4;
        in_md.in_delay_slot   = in_data.in_delay_slot;
        in_md.cp0_cause       = in_data.cp0_cause;
        in_md.cp0_status      = in_data.cp0_status;
        in_md.exception_instr = in_data.exception_instr;
        in_md.exception_ri    = in_data.exception_ri;
        in_md.exception_of    = in_data.exception_of;
        in_md.i_tlb_refill    = in_data.i_tlb_refill;
        in_md.i_tlb_invalid   = in_data.i_tlb_invalid;
        in_md.result          = in_data.aluout;
        in_md.exception_adel  = !in_bypass && misaligned && in_op.read;
        in_md.exception_ades  = !in_bypass && misaligned && in_op.write;
        if (in_md.exception_adel || in_md.exception_ades)
            in_md.badvaddr = in_data.aluout;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (in_bypass || misaligned) ? DONE : ADDR;
            ADDR: if (dresp_addr_ok)
                      state_next = dresp_data_ok ? (squash ? IDLE : DONE) : DATA;
            DATA: if (dresp_data_ok) state_next = squash ? IDLE : DONE;
            DONE: if (accept)                  state_next = (in_bypass || misaligned) ? DONE : ADDR;
                  else if (out_ready || flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            addr_q    <= '0;
            strobe_q  <= '0;
            data_q    <= '0;
            out_q     <= '0;
            flushed_q <= 1'b0;
        end else if (accept) begin
            op_q      <= in_op;
            addr_q    <= in_data.aluout;
            strobe_q  <= strobe;
            data_q    <= sdata;
            out_q     <= in_md;
            flushed_q <= 1'b0;
        end else begin
            // A request cannot be withdrawn, so a flush is remembered until it completes.
            if (stall && flush)
                flushed_q <= 1'b1;
            if (complete) begin
                flushed_q <= 1'b0;
                if (op_q.read)
                    out_q.result <= ldata;
            end
        end
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == ADDR);
        dreq.addr   = addr_q;
        dreq.size   = op_q.size;
        dreq.strobe = strobe_q;
        dreq.data   = data_q;
    end

    assign dreq_valid  = dreq.valid;
    assign dreq_addr   = dreq.addr;
    assign dreq_size   = dreq.size;
    assign dreq_strobe = dreq.strobe;
    assign dreq_data   = dreq.data;
    assign out_valid   = (state == DONE) && !flush;
    assign out_data    = out_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed plus randomized checks of memory_stage against a byte-lane
// arithmetic reference model.
module tb_memory_stage;
    import common::*;
    import memory_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    execute_data_t in_data;
    logic          in_ready;
    logic          flush;
    logic          dreq_valid;
    logic [31:0]   dreq_addr;
    logic [2:0]    dreq_size;
    logic [3:0]    dreq_strobe;
    logic [31:0]   dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    logic [31:0]   dresp_data;
    logic          out_valid;
    memory_data_t  out_data;
    logic          out_ready;
    logic          stall;

    int checks = 0;
    int errors = 0;

    memory_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .dreq_valid(dreq_valid),
        .dreq_addr(dreq_addr), .dreq_size(dreq_size), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input decoded_op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_load(input decoded_op_t op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic [31:0] model_load(input decoded_op_t op, input logic [1:0] off,
                                               input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * int'(off));
        if (nbytes(op) == 1) begin
            v = v & 32'hFF;
            if (op == OP_LB && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (nbytes(op) == 2) begin
            v = v & 32'hFFFF;
            if (op == OP_LH && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic execute_data_t mk(input decoded_op_t op, input logic [31:0] a,
                                         input logic [31:0] wd);
        execute_data_t e;
        logic [31:0] r;
        e = '0;
        e.instr.op   = op;
        e.aluout     = a;
        e.writedata  = wd;
        r = $urandom; e.writereg = r[4:0]; e.in_delay_slot = r[5];
        e.hi = $urandom; e.lo = $urandom; e.pcplus4 = $urandom;
        e.cp0_cause = $urandom; e.cp0_status = $urandom;
        return e;
    endfunction

    // Drive one instruction from IDLE, play the bus with the given latencies,
    // and check the request and the result against the model.
    task automatic do_instr(input execute_data_t ed, input int aw, input int dw,
                            input logic [31:0] word, output logic [31:0] res);
        int nb, si;
        bit ld, byp, mis;
        logic [1:0]  off;
        logic [31:0] exp, r, sexp;
        nb  = nbytes(ed.instr.op);
        ld  = is_load(ed.instr.op);
        off = ed.aluout[1:0];
        byp = (nb == 0) || ed.exception_instr || ed.exception_ri || ed.exception_of ||
              ed.i_tlb_refill || ed.i_tlb_invalid;
        mis = 1'b0;
        if (!byp) mis = (int'(off) % nb) != 0;
        exp = ed.aluout;
        si  = ((1 << nb) - 1) << int'(off);
        sexp = (nb == 1) ? ed.writedata[7:0] * 32'h0101_0101 :
               (nb == 2) ? ed.writedata[15:0] * 32'h0001_0001 : ed.writedata;
        in_valid = 1'b1; in_data = ed; #1;
        chk("in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        if (!byp && !mis) begin
            for (int c = 0; c <= aw; c++) begin
                chk("dreq_valid", {31'b0, dreq_valid}, 32'd1);
                chk("stall_addr", {31'b0, stall}, 32'd1);
                chk("dreq_addr", dreq_addr, ed.aluout);
                chk("dreq_size", {29'b0, dreq_size},
                    (nb == 1) ? 32'(MSIZE1) : (nb == 2) ? 32'(MSIZE2) : 32'(MSIZE4));
                chk("dreq_strobe", {28'b0, dreq_strobe}, ld ? 32'd0 : 32'(si & 15));
                if (!ld) chk("dreq_data", dreq_data, sexp);
                if (c == aw) begin
                    dresp_addr_ok = 1'b1; dresp_data_ok = (dw == 0); dresp_data = word;
                end else begin
                    r = $urandom; dresp_data_ok = r[0]; dresp_data = $urandom;
                end
                tick();
                dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
            end
            for (int k = 1; k <= dw; k++) begin
                chk("dreq_drop", {31'b0, dreq_valid}, 32'd0);
                chk("stall_data", {31'b0, stall}, 32'd1);
                if (k == dw) begin dresp_data_ok = 1'b1; dresp_data = word; end
                tick();
                dresp_data_ok = 1'b0;
            end
            if (ld) exp = model_load(ed.instr.op, off, word);
        end else begin
            chk("no_dreq", {31'b0, dreq_valid}, 32'd0);
        end
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_done", {31'b0, stall}, 32'd0);
        chk("result", out_data.result, exp);
        chk("adel", {31'b0, out_data.exception_adel}, {31'b0, mis && ld});
        chk("ades", {31'b0, out_data.exception_ades}, {31'b0, mis && !ld});
        chk("badvaddr", out_data.badvaddr, mis ? ed.aluout : 32'd0);
        chk("pcplus4", out_data.pcplus4, ed.pcplus4);
        chk("writereg", {27'b0, out_data.writereg}, {27'b0, ed.writereg});
        chk("exc_ri", {31'b0, out_data.exception_ri}, {31'b0, ed.exception_ri});
        res = out_data.result;
        tick();
    endtask

    initial begin
        execute_data_t a, b;
        logic [31:0] res, r;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_dreq_valid", {31'b0, dreq_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {31'b0, |out_data}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_stall", {31'b0, stall}, 32'd0);

        do_instr(mk(OP_LW, 32'h8000_1004, 32'h0), 0, 0, 32'hDEAD_BEEF, res);
        chk("lw_lit", res, 32'hDEAD_BEEF);
        do_instr(mk(OP_LB, 32'h8000_1003, 32'h0), 1, 3, 32'h8011_2233, res);
        chk("lb_lit", res, 32'hFFFF_FF80);
        do_instr(mk(OP_LBU, 32'h8000_1003, 32'h0), 1, 3, 32'h8011_2233, res);
        chk("lbu_lit", res, 32'h0000_0080);
        do_instr(mk(OP_LH, 32'h8000_1002, 32'h0), 0, 1, 32'h9ABC_1234, res);
        chk("lh_lit", res, 32'hFFFF_9ABC);

        a = mk(OP_SH, 32'h8000_1002, 32'h0000_ABCD);
        in_valid = 1'b1; in_data = a; tick(); in_valid = 1'b0;
        chk("sh_strobe_lit", {28'b0, dreq_strobe}, 32'h0000_000C);
        chk("sh_data_lit", dreq_data, 32'hABCD_ABCD);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; tick();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; tick();
        do_instr(mk(OP_SH, 32'h8000_1002, 32'h0000_ABCD), 2, 0, 32'h0, res);
        do_instr(mk(OP_SH, 32'h8000_1001, 32'h0000_ABCD), 0, 0, 32'h0, res);
        do_instr(mk(OP_LW, 32'h8000_1006, 32'h0), 0, 0, 32'h0, res);
        do_instr(mk(OP_SB, 32'h8000_1001, 32'h0000_0077), 1, 1, 32'h0, res);

        // ADDU held in DONE while LW waits at the input.
        a = mk(OP_ADDU, 32'h1234_5678, 32'h0);
        b = mk(OP_LW, 32'h8000_2000, 32'h0);
        in_valid = 1'b1; in_data = a; tick();
        out_ready = 1'b0; in_data = b; #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_result", out_data.result, 32'h1234_5678);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_dreq", {31'b0, dreq_valid}, 32'd1);
        chk("b2b_addr", dreq_addr, 32'h8000_2000);
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'hCAFE_F00D; tick();
        dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_result", out_data.result, 32'hCAFE_F00D);
        tick();

        // Flush while waiting for data: the load completes silently.
        in_valid = 1'b1; in_data = mk(OP_LW, 32'h8000_3000, 32'h0); tick();
        in_valid = 1'b0; dresp_addr_ok = 1'b1; tick();
        dresp_addr_ok = 1'b0;
        chk("fl_in_data", {31'b0, stall}, 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fl_stall", {31'b0, stall}, 32'd1);
        chk("fl_no_out", {31'b0, out_valid}, 32'd0);
        dresp_data_ok = 1'b1; dresp_data = 32'h1111_2222; tick(); dresp_data_ok = 1'b0;
        chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_after_stall", {31'b0, stall}, 32'd0);
        chk("fl_after_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("fl_still_quiet", {31'b0, out_valid}, 32'd0);
        do_instr(mk(OP_ADDU, 32'h0BAD_F00D, 32'h0), 0, 0, 32'h0, res);

        // Reset while a request is on the bus.
        in_valid = 1'b1; in_data = mk(OP_LW, 32'h8000_4000, 32'h0); tick();
        in_valid = 1'b0;
        chk("mid_dreq", {31'b0, dreq_valid}, 32'd1);
        reset = 1'b1; tick();
        chk("mid_rst_dreq", {31'b0, dreq_valid}, 32'd0);
        chk("mid_rst_out", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0; tick();

        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            a = mk(decoded_op_t'($urandom_range(9, 0)), 32'h8000_0000 | ($urandom & 32'hFFFF),
                   $urandom);
            if (r[3:0] == 4'd0) a.exception_ri = 1'b1;
            if (r[7:4] == 4'd0) a.i_tlb_refill = 1'b1;
            do_instr(a, int'(r[9:8]), int'(r[11:10]), $urandom, res);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
